dtw_query_loader: RTL
=====================

// Module: dtw_query_loader
// PURPOSE
// - Downstream consumer of the dtw_accel S00_AXIS sample FIFO. Pops 8-bit query samples and frames QUERY_LEN of them
//   into one indexed query, then streams them to the DTW core over a valid/ready port.
// - Keeps a running sample sum for core normalisation. Signals done once the last sample is accepted.
// PARAMETERS
// - DATA_WIDTH  8    sample width; equals the FIFO dout width (C_S_AXIS_TDATA_WIDTH/4)
// - QUERY_LEN   250  samples per query frame (>=2)
// - IDX_W       localparam max(1, ceil(log2(QUERY_LEN))); width of the sample index
// - SUM_W       localparam DATA_WIDTH+ceil(log2(QUERY_LEN)); width of the running sum
// PORTS
// - S_AXIS_ACLK     in   1           single clock, rising edge; shared with the S00_AXIS sink
// - S_AXIS_ARESETN  in   1           asynchronous, active-low reset
// - dtw_fifo_dout   in   DATA_WIDTH  FIFO head sample; show-ahead, valid whenever !dtw_fifo_empty
// - dtw_fifo_empty  in   1           FIFO empty
// - dtw_fifo_rden   out  1           pop strobe; the head is consumed this cycle
// - start           in   1           1-cycle arm pulse from control
// - abort           in   1           1-cycle cancel pulse
// - q_valid         out  1           query sample valid
// - q_ready         in   1           DTW core accepts the sample
// - q_data          out  DATA_WIDTH  query sample
// - q_idx           out  IDX_W       sample index within the frame
// - q_first         out  1           q_idx==0
// - q_last          out  1           q_idx==QUERY_LEN-1
// - busy            out  1           state != IDLE
// - done            out  1           1-cycle pulse when a frame completes
// - q_sum           out  SUM_W       unsigned sum of the current/last frame
// - frame_cnt       out  16          count of completed frames; wraps at 0xFFFF->0
// BEHAVIOUR
// - Reset: all outputs 0; state IDLE; issue index 0.
// - State IDLE
//   - dtw_fifo_rden=0.
//   - start -> FETCH; clears issue index and q_sum.
//   - start in any other state is ignored.
// - State FETCH
//   - dtw_fifo_rden = !dtw_fifo_empty && (!q_valid || q_ready). Combinational.
//   - On a pop:
//     - q_data <= dtw_fifo_dout; q_valid <= 1; q_idx <= issue index.
//     - q_first and q_last set from the issue index.
//     - q_sum <= q_sum + zero-extended dout.
//     - Issue index increments.
//   - Pop with issue index == QUERY_LEN-1 -> DRAIN.
//   - Consumer handshake without a pop: q_valid <= 0.
// - State DRAIN
//   - No pops.
//   - Handshake on the last sample: q_valid <= 0 -> DONE.
// - State DONE
//   - done=1 for exactly one cycle; frame_cnt increments.
//   - Next state IDLE. q_sum holds until the next start.
// - Latency and throughput
//   - A sample popped in cycle N appears on q_data in cycle N+1.
//   - Sustained throughput is 1 sample/cycle while the FIFO is non-empty and q_ready=1.
// - AXIS-style hold rule
//   - While q_valid && !q_ready: q_data/q_idx/q_first/q_last are stable and no pop occurs.
// - FIFO empty mid-frame
//   - Insert bubbles; no pop and no reorder.
//   - q_valid drops after the pending handshake.
// - abort
//   - From any state: next cycle state IDLE, q_valid 0, no done, frame_cnt unchanged.
//   - Samples already popped are discarded; q_sum is frozen.
//   - abort wins over start in the same cycle.
// - Never pop when dtw_fifo_empty=1. Never pop more than QUERY_LEN samples per frame.
// - Reset asserted mid-frame: immediate return to reset values; the FIFO is untouched by this block.
// STRUCTURE
// - Shared include dtw_defines.vh holds:
//   - DTW_SAMPLE_W=8 and DTW_QUERY_LEN.
//   - State encodings IDLE=2'd0, FETCH=2'd1, DRAIN=2'd2, DONE=2'd3.
//   - ceil-log2 function (correct at exact powers of 2).
// - Single module, no sub-module: state register, issue counter, output register, accumulator, frame counter.
// TESTING (QUERY_LEN=4 unless stated)
// - FIFO holds 10,20,30,40 (hex), q_ready=1, start
//   -> rden high for 4 consecutive cycles
//   -> q_data 10,20,30,40 with q_idx 0..3; q_first on idx0, q_last on idx3
//   -> done 2 cycles after the last pop; q_sum=0xA0; frame_cnt=1.
// - q_ready low for 3 cycles while idx1 is valid
//   -> q_data=20 and q_idx=1 stable; rden=0 throughout; no loss or duplication.
// - FIFO empty for 2 cycles after idx1
//   -> rden=0 and q_valid=0 during the gap; frame completes with correct indices.
// - 4 samples of FF -> q_sum=0x3FC (fits SUM_W=10).
// - abort after 2 pops
//   -> IDLE next cycle, q_valid=0, no done, frame_cnt unchanged.
//   -> A fresh start restarts at q_idx=0 with q_sum cleared.
// - Negative edges and ordering
//   - start during FETCH ignored.
//   - start+abort in the same cycle -> stays IDLE.
//   - ARESETN low mid-frame -> all outputs 0 immediately.

Source files
------------

// File: rtl/dtw_query_loader_pkg.sv
// dtw_query_loader_pkg
//   Shared definitions for the DTW query loader: default sample width and
//   query length, the loader state encoding, and a ceil-log2 helper that is
//   exact at powers of two (clog2(4)=2, clog2(5)=3).
package dtw_query_loader_pkg;

   localparam int DTW_SAMPLE_W  = 8;
   localparam int DTW_QUERY_LEN = 250;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   function automatic int dtw_clog2(input int value);
      int result;
      int v;
      result = 0;
      v      = value - 1;
      while (v > 0) begin
         result = result + 1;
         v      = v >>> 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/dtw_query_loader.sv
// dtw_query_loader
//   Pops samples from the show-ahead S00_AXIS sample FIFO, frames QUERY_LEN of
//   them into one indexed query and streams them to the DTW core over a
//   valid/ready port. Keeps a running unsigned sum of the frame and counts
//   completed frames.
// Ports
//   S_AXIS_ACLK     clock, rising edge
//   S_AXIS_ARESETN  asynchronous active-low reset
//   dtw_fifo_dout   FIFO head sample (valid while !dtw_fifo_empty)
//   dtw_fifo_empty  FIFO empty flag
//   dtw_fifo_rden   pop strobe, head consumed this cycle
//   start / abort   1-cycle arm / cancel pulses (abort wins)
//   q_valid/q_ready query sample handshake
//   q_data/q_idx    sample and its index within the frame
//   q_first/q_last  index is 0 / QUERY_LEN-1
//   busy            loader not idle
//   done            1-cycle pulse when a frame completes
//   q_sum           running sum of the current/last frame
//   frame_cnt       completed frame counter, wraps
module dtw_query_loader
   import dtw_query_loader_pkg::*;
#(
   parameter  int DATA_WIDTH = DTW_SAMPLE_W,
   parameter  int QUERY_LEN  = DTW_QUERY_LEN,
   localparam int IDX_W      = (dtw_clog2(QUERY_LEN) < 1) ? 1 : dtw_clog2(QUERY_LEN),
   localparam int SUM_W      = DATA_WIDTH + dtw_clog2(QUERY_LEN)
) (
   input  logic                  S_AXIS_ACLK,
   input  logic                  S_AXIS_ARESETN,
   input  logic [DATA_WIDTH-1:0] dtw_fifo_dout,
   input  logic                  dtw_fifo_empty,
   output logic                  dtw_fifo_rden,
   input  logic                  start,
   input  logic                  abort,
   output logic                  q_valid,
   input  logic                  q_ready,
   output logic [DATA_WIDTH-1:0] q_data,
   output logic [IDX_W-1:0]      q_idx,
   output logic                  q_first,
   output logic                  q_last,
   output logic                  busy,
   output logic                  done,
   output logic [SUM_W-1:0]      q_sum,
   output logic [15:0]           frame_cnt
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(QUERY_LEN - 1);

   state_t                  state_reg, state_next;
   logic [IDX_W-1:0]        issue_idx_reg;
   logic                    q_valid_reg;
   logic [DATA_WIDTH-1:0]   q_data_reg;
   logic [IDX_W-1:0]        q_idx_reg;
   logic                    q_first_reg;
   logic                    q_last_reg;
   logic [SUM_W-1:0]        q_sum_reg;
   logic [15:0]             frame_cnt_reg;
   logic                    pop;
   logic                    handshake;

   assign handshake = q_valid_reg && q_ready;

   always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
      if (!S_AXIS_ARESETN) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Pops are suppressed during abort so a cancelled frame never swallows a
   // sample that would otherwise be discarded.
   always_comb begin
      state_next = state_reg;
      pop        = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (start) state_next = ST_FETCH;
         end
         ST_FETCH: begin
            pop = !dtw_fifo_empty && (!q_valid_reg || q_ready) && !abort;
            if (pop && (issue_idx_reg == LAST_IDX)) state_next = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (handshake) state_next = ST_DONE;
         end
         ST_DONE: begin
            state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
      if (abort) state_next = ST_IDLE;
   end

   always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
      if (!S_AXIS_ARESETN) begin
         issue_idx_reg <= '0;
         q_valid_reg   <= 1'b0;
         q_data_reg    <= '0;
         q_idx_reg     <= '0;
         q_first_reg   <= 1'b0;
         q_last_reg    <= 1'b0;
         q_sum_reg     <= '0;
         frame_cnt_reg <= '0;
      end else if (abort) begin
         // Pending sample is dropped; sum and counters freeze.
         q_valid_reg <= 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (start) begin
                  issue_idx_reg <= '0;
                  q_sum_reg     <= '0;
               end
            end
            ST_FETCH: begin
               if (pop) begin
                  q_data_reg    <= dtw_fifo_dout;
                  q_valid_reg   <= 1'b1;
                  q_idx_reg     <= issue_idx_reg;
                  q_first_reg   <= (issue_idx_reg == '0);
                  q_last_reg    <= (issue_idx_reg == LAST_IDX);
                  q_sum_reg     <= q_sum_reg + SUM_W'(dtw_fifo_dout);
                  issue_idx_reg <= issue_idx_reg + IDX_W'(1);
               end else if (handshake) begin
                  q_valid_reg <= 1'b0;
               end
            end
            ST_DRAIN: begin
               // Counter moves together with the done pulse.
               if (handshake) begin
                  q_valid_reg   <= 1'b0;
                  frame_cnt_reg <= frame_cnt_reg + 16'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign dtw_fifo_rden = pop;
   assign q_valid       = q_valid_reg;
   assign q_data        = q_data_reg;
   assign q_idx         = q_idx_reg;
   assign q_first       = q_first_reg;
   assign q_last        = q_last_reg;
   assign q_sum         = q_sum_reg;
   assign frame_cnt     = frame_cnt_reg;
   assign busy          = (state_reg != ST_IDLE);
   assign done          = (state_reg == ST_DONE);

endmodule
